// File: rtl/time_set_controller_if.sv
// Signal bundle between the time-setting front end and its button, timer-bus and display neighbours.
// The slave modport is the controller's view; the master modport is the surrounding logic's view.
interface time_set_controller_if;
  logic       modeBtn_in;
  logic       incBtn_in;
  logic       decBtn_in;
  logic [7:0] bcdHour_in;
  logic [7:0] bcdMinute_in;
  logic [7:0] bcdSecond_in;
  logic [7:0] bcdHour_out;
  logic [7:0] bcdMinute_out;
  logic [7:0] bcdSecond_out;
  logic       adjustCmd_out;
  logic [1:0] fieldSel_out;
  logic       blink_out;

  modport slave (
    input  modeBtn_in, incBtn_in, decBtn_in,
    input  bcdHour_in, bcdMinute_in, bcdSecond_in,
    output bcdHour_out, bcdMinute_out, bcdSecond_out,
    output adjustCmd_out, fieldSel_out, blink_out
  );

  modport master (
    output modeBtn_in, incBtn_in, decBtn_in,
    output bcdHour_in, bcdMinute_in, bcdSecond_in,
    input  bcdHour_out, bcdMinute_out, bcdSecond_out,
    input  adjustCmd_out, fieldSel_out, blink_out
  );
endinterface

// File: rtl/time_set_controller.sv
// Button-driven H:M:S editor: captures the live BCD time, steps the selected field with
// press and auto-repeat, and holds the timer adjust command while editing.
module time_set_controller #(
  parameter int unsigned HOLD_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000,
  parameter int unsigned BLINK_CYCLES  = 25_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  time_set_controller_if.slave  bus
);

  localparam int unsigned RPT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned CW      = $clog2(RPT_MAX + 1);
  localparam int unsigned BW      = $clog2(BLINK_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_RELOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REP_RELOAD  = CW'(REPEAT_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_CYCLES - 1);

  // Encoding doubles as the field-select code driven to the display.
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10,
    SET_SEC  = 2'b11
  } state_e;

  state_e        state_q;
  logic [7:0]    hour_q, min_q, sec_q;
  logic          adj_q;
  logic          blink_q;
  logic [BW-1:0] blink_cnt_q;

  // Bit order {mode, inc, dec}.
  logic [2:0]    btn_s1_q, btn_s2_q, btn_prev_q;
  logic          mode_press, inc_press, dec_press, both_held;

  logic          rpt_act_q, rpt_act_d;
  logic          rpt_inc_q, rpt_inc_d;
  logic [CW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic          step_inc, step_dec;

  function automatic logic [7:0] bcd_clean(input logic [7:0] v, input logic [7:0] maxv);
    if (v[7:4] > 4'd9 || v[3:0] > 4'd9 || v > maxv) return 8'h00;
    return v;
  endfunction

  function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic [7:0] maxv,
                                          input logic up);
    if (up) begin
      if (v == maxv)        return 8'h00;
      if (v[3:0] == 4'd9)   return {v[7:4] + 4'd1, 4'd0};
      return {v[7:4], v[3:0] + 4'd1};
    end
    if (v == 8'h00)         return maxv;
    if (v[3:0] == 4'd0)     return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  assign mode_press = btn_s2_q[2] & ~btn_prev_q[2];
  assign inc_press  = btn_s2_q[1] & ~btn_prev_q[1];
  assign dec_press  = btn_s2_q[0] & ~btn_prev_q[0];
  assign both_held  = btn_s2_q[1] & btn_s2_q[0];

  // Repeat counter counts down from the press; reaching zero while the same
  // button is still held yields a step and reloads with the repeat period.
  always_comb begin
    step_inc  = 1'b0;
    step_dec  = 1'b0;
    rpt_act_d = rpt_act_q;
    rpt_inc_d = rpt_inc_q;
    rpt_cnt_d = rpt_cnt_q;
    if (state_q == IDLE || mode_press || both_held) begin
      rpt_act_d = 1'b0;
      rpt_cnt_d = '0;
    end else if (inc_press) begin
      step_inc  = 1'b1;
      rpt_act_d = 1'b1;
      rpt_inc_d = 1'b1;
      rpt_cnt_d = HOLD_RELOAD;
    end else if (dec_press) begin
      step_dec  = 1'b1;
      rpt_act_d = 1'b1;
      rpt_inc_d = 1'b0;
      rpt_cnt_d = HOLD_RELOAD;
    end else if (rpt_act_q) begin
      if (!(rpt_inc_q ? btn_s2_q[1] : btn_s2_q[0])) begin
        rpt_act_d = 1'b0;
        rpt_cnt_d = '0;
      end else if (rpt_cnt_q == '0) begin
        step_inc  = rpt_inc_q;
        step_dec  = ~rpt_inc_q;
        rpt_cnt_d = REP_RELOAD;
      end else begin
        rpt_cnt_d = rpt_cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hour_q      <= '0;
      min_q       <= '0;
      sec_q       <= '0;
      adj_q       <= 1'b0;
      blink_q     <= 1'b1;
      blink_cnt_q <= '0;
      btn_s1_q    <= '0;
      btn_s2_q    <= '0;
      btn_prev_q  <= '0;
      rpt_act_q   <= 1'b0;
      rpt_inc_q   <= 1'b0;
      rpt_cnt_q   <= '0;
    end else begin
      btn_s1_q   <= {bus.modeBtn_in, bus.incBtn_in, bus.decBtn_in};
      btn_s2_q   <= btn_s1_q;
      btn_prev_q <= btn_s2_q;
      rpt_act_q  <= rpt_act_d;
      rpt_inc_q  <= rpt_inc_d;
      rpt_cnt_q  <= rpt_cnt_d;

      if (mode_press) begin
        blink_q     <= 1'b1;
        blink_cnt_q <= '0;
        case (state_q)
          IDLE: begin
            state_q <= SET_HOUR;
            adj_q   <= 1'b1;
            hour_q  <= bcd_clean(bus.bcdHour_in,   8'h23);
            min_q   <= bcd_clean(bus.bcdMinute_in, 8'h59);
            sec_q   <= bcd_clean(bus.bcdSecond_in, 8'h59);
          end
          SET_HOUR: state_q <= SET_MIN;
          SET_MIN:  state_q <= SET_SEC;
          default: begin
            state_q <= IDLE;
            adj_q   <= 1'b0;
          end
        endcase
      end else if (step_inc || step_dec) begin
        blink_q     <= 1'b1;
        blink_cnt_q <= '0;
        case (state_q)
          SET_HOUR: hour_q <= bcd_step(hour_q, 8'h23, step_inc);
          SET_MIN:  min_q  <= bcd_step(min_q,  8'h59, step_inc);
          SET_SEC:  sec_q  <= bcd_step(sec_q,  8'h59, step_inc);
          default:  ;
        endcase
      end else if (state_q == IDLE) begin
        blink_q     <= 1'b1;
        blink_cnt_q <= '0;
      end else if (blink_cnt_q == BLINK_LAST) begin
        blink_q     <= ~blink_q;
        blink_cnt_q <= '0;
      end else begin
        blink_cnt_q <= blink_cnt_q + BW'(1);
      end
    end
  end

  assign bus.bcdHour_out   = hour_q;
  assign bus.bcdMinute_out = min_q;
  assign bus.bcdSecond_out = sec_q;
  assign bus.adjustCmd_out = adj_q;
  assign bus.fieldSel_out  = state_q;
  assign bus.blink_out     = blink_q;

endmodule

// File: tb/tb_time_set_controller.sv
// Self-checking bench for time_set_controller: vector table, hand sequences for repeat/blink/reset,
// and randomized stimulus against an edge-count based reference model.
module tb_time_set_controller;
  localparam int HOLD = 8;
  localparam int REP  = 4;
  localparam int BLK  = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  time_set_controller_if bus();

  time_set_controller #(
    .HOLD_CYCLES  (HOLD),
    .REPEAT_CYCLES(REP),
    .BLINK_CYCLES (BLK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: decimal time, field index, and edge numbers of the last
  // press and last blink restart; blink phase follows from elapsed edges.
  int m_field, m_h, m_m, m_s, m_adj, m_edge, m_press_edge, m_blink_ref;
  bit m_rpt_on, m_rpt_inc;
  bit [2:0] m_d1, m_d2, m_d3;

  typedef struct {
    bit         mode, inc, dec;
    int         hold;
    logic [7:0] hin, mn_in, sin;
    logic [1:0] fs;
    bit         adj;
    logic [7:0] h, m, s;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(bit mo, bit in, bit de, logic [7:0] hi, logic [7:0] mi, logic [7:0] si,
                              logic [1:0] fs, bit adj, logic [7:0] h, logic [7:0] m, logic [7:0] s);
    vec_t v;
    v.mode = mo; v.inc = in; v.dec = de; v.hold = 1;
    v.hin = hi; v.mn_in = mi; v.sin = si;
    v.fs = fs; v.adj = adj; v.h = h; v.m = m; v.s = s;
    return v;
  endfunction

  function automatic int bcd2dec(logic [7:0] v, int maxv);
    int hi, lo, val;
    hi = int'(v[7:4]);
    lo = int'(v[3:0]);
    if (hi > 9 || lo > 9) return 0;
    val = hi * 10 + lo;
    return (val > maxv) ? 0 : val;
  endfunction

  function automatic logic [7:0] dec2bcd(int x);
    return 8'(((x / 10) << 4) + (x % 10));
  endfunction

  function automatic logic [7:0] rnd_bcd(int maxv);
    if ($urandom_range(0, 3) == 0) return 8'($urandom);
    return dec2bcd(int'($urandom_range(0, maxv)));
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic model_edge();
    bit [2:0] s2v, pv, pr;
    int stepdir, d;
    m_edge++;
    if (rst) begin
      m_field = 0; m_h = 0; m_m = 0; m_s = 0; m_adj = 0;
      m_rpt_on = 0; m_d1 = '0; m_d2 = '0; m_d3 = '0;
      m_blink_ref = m_edge;
      return;
    end
    s2v = m_d2;
    pv  = m_d3;
    m_d3 = m_d2;
    m_d2 = m_d1;
    m_d1 = {bus.modeBtn_in, bus.incBtn_in, bus.decBtn_in};
    pr = s2v & ~pv;
    stepdir = 0;
    if (m_field == 0 || pr[2] || (s2v[1] && s2v[0])) m_rpt_on = 0;
    else if (pr[1]) begin stepdir = 1;  m_rpt_on = 1; m_rpt_inc = 1; m_press_edge = m_edge; end
    else if (pr[0]) begin stepdir = -1; m_rpt_on = 1; m_rpt_inc = 0; m_press_edge = m_edge; end
    else if (m_rpt_on) begin
      if (!(m_rpt_inc ? s2v[1] : s2v[0])) m_rpt_on = 0;
      else begin
        d = m_edge - m_press_edge;
        if (d == HOLD || (d > HOLD && (d - HOLD) % REP == 0)) stepdir = m_rpt_inc ? 1 : -1;
      end
    end
    if (pr[2]) begin
      m_field = (m_field + 1) % 4;
      if (m_field == 1) begin
        m_h = bcd2dec(bus.bcdHour_in, 23);
        m_m = bcd2dec(bus.bcdMinute_in, 59);
        m_s = bcd2dec(bus.bcdSecond_in, 59);
        m_adj = 1;
      end
      if (m_field == 0) m_adj = 0;
      m_blink_ref = m_edge;
    end else if (stepdir != 0) begin
      case (m_field)
        1: m_h = (m_h + 24 + stepdir) % 24;
        2: m_m = (m_m + 60 + stepdir) % 60;
        3: m_s = (m_s + 60 + stepdir) % 60;
        default: ;
      endcase
      m_blink_ref = m_edge;
    end else if (m_field == 0) begin
      m_blink_ref = m_edge;
    end
  endtask

  function automatic logic [27:0] act_vec();
    return {bus.adjustCmd_out, bus.fieldSel_out, bus.blink_out,
            bus.bcdHour_out, bus.bcdMinute_out, bus.bcdSecond_out};
  endfunction

  function automatic logic [27:0] exp_vec();
    bit b;
    b = (((m_edge - m_blink_ref) / BLK) % 2) == 0;
    return {m_adj[0], 2'(m_field), b, dec2bcd(m_h), dec2bcd(m_m), dec2bcd(m_s)};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("model", 32'(act_vec()), 32'(exp_vec()));
  endtask

  task automatic set_btn(bit mo, bit in, bit de);
    bus.modeBtn_in = mo;
    bus.incBtn_in  = in;
    bus.decBtn_in  = de;
  endtask

  task automatic pulse(bit mo, bit in, bit de, int cycles);
    set_btn(mo, in, de);
    repeat (cycles) tick();
    set_btn(0, 0, 0);
    repeat (5) tick();
  endtask

  task automatic set_time(logic [7:0] h, logic [7:0] m, logic [7:0] s);
    bus.bcdHour_in = h; bus.bcdMinute_in = m; bus.bcdSecond_in = s;
  endtask

  initial begin
    bit found;
    m_edge = 0; m_blink_ref = 0; m_field = 0; m_h = 0; m_m = 0; m_s = 0; m_adj = 0;
    m_rpt_on = 0; m_rpt_inc = 0; m_press_edge = 0; m_d1 = '0; m_d2 = '0; m_d3 = '0;
    rst = 1'b1;
    set_btn(0, 0, 0);
    set_time(8'h00, 8'h00, 8'h00);

    tbl.push_back(mk(1,0,0, 8'h12,8'h34,8'h56, 2'd1,1, 8'h12,8'h34,8'h56));
    tbl.push_back(mk(0,1,0, 8'h12,8'h34,8'h56, 2'd1,1, 8'h13,8'h34,8'h56));
    tbl.push_back(mk(0,0,1, 8'h12,8'h34,8'h56, 2'd1,1, 8'h12,8'h34,8'h56));
    tbl.push_back(mk(1,0,0, 8'h12,8'h34,8'h56, 2'd2,1, 8'h12,8'h34,8'h56));
    tbl.push_back(mk(0,1,0, 8'h12,8'h34,8'h56, 2'd2,1, 8'h12,8'h35,8'h56));
    tbl.push_back(mk(1,0,0, 8'h12,8'h34,8'h56, 2'd3,1, 8'h12,8'h35,8'h56));
    tbl.push_back(mk(0,0,1, 8'h12,8'h34,8'h56, 2'd3,1, 8'h12,8'h35,8'h55));
    tbl.push_back(mk(1,0,0, 8'h12,8'h34,8'h56, 2'd0,0, 8'h12,8'h35,8'h55));
    tbl.push_back(mk(1,0,0, 8'h23,8'h7A,8'h40, 2'd1,1, 8'h23,8'h00,8'h40));
    tbl.push_back(mk(0,1,0, 8'h23,8'h7A,8'h40, 2'd1,1, 8'h00,8'h00,8'h40));
    tbl.push_back(mk(1,0,0, 8'h23,8'h7A,8'h40, 2'd2,1, 8'h00,8'h00,8'h40));
    tbl.push_back(mk(0,0,1, 8'h23,8'h7A,8'h40, 2'd2,1, 8'h00,8'h59,8'h40));
    tbl.push_back(mk(0,1,0, 8'h23,8'h7A,8'h40, 2'd2,1, 8'h00,8'h00,8'h40));
    tbl.push_back(mk(1,0,0, 8'h23,8'h7A,8'h40, 2'd3,1, 8'h00,8'h00,8'h40));
    tbl.push_back(mk(0,0,1, 8'h23,8'h7A,8'h40, 2'd3,1, 8'h00,8'h00,8'h39));
    tbl.push_back(mk(0,1,1, 8'h23,8'h7A,8'h40, 2'd3,1, 8'h00,8'h00,8'h39));
    tbl.push_back(mk(1,0,0, 8'h23,8'h7A,8'h40, 2'd0,0, 8'h00,8'h00,8'h39));
    tbl.push_back(mk(1,0,0, 8'h24,8'h09,8'h00, 2'd1,1, 8'h00,8'h09,8'h00));
    tbl.push_back(mk(1,0,0, 8'h24,8'h09,8'h00, 2'd2,1, 8'h00,8'h09,8'h00));
    tbl.push_back(mk(1,0,0, 8'h24,8'h09,8'h00, 2'd3,1, 8'h00,8'h09,8'h00));
    tbl.push_back(mk(0,0,1, 8'h24,8'h09,8'h00, 2'd3,1, 8'h00,8'h09,8'h59));
    tbl.push_back(mk(0,1,0, 8'h24,8'h09,8'h00, 2'd3,1, 8'h00,8'h09,8'h00));
    tbl.push_back(mk(1,0,0, 8'h24,8'h09,8'h00, 2'd0,0, 8'h00,8'h09,8'h00));

    repeat (2) tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("reset idle", 32'(act_vec()), 32'h0100_0000);
    end

    foreach (tbl[i]) begin
      set_time(tbl[i].hin, tbl[i].mn_in, tbl[i].sin);
      pulse(tbl[i].mode, tbl[i].inc, tbl[i].dec, tbl[i].hold);
      chk($sformatf("tbl%0d fieldSel", i), 32'(bus.fieldSel_out), 32'(tbl[i].fs));
      chk($sformatf("tbl%0d adjust", i), 32'(bus.adjustCmd_out), 32'(tbl[i].adj));
      chk($sformatf("tbl%0d time", i),
          {8'h00, bus.bcdHour_out, bus.bcdMinute_out, bus.bcdSecond_out},
          {8'h00, tbl[i].h, tbl[i].m, tbl[i].s});
    end

    // Enter SET_MIN at 10, checking the blink cadence on entry, then hold inc.
    set_time(8'h10, 8'h10, 8'h10);
    pulse(1, 0, 0, 1);
    set_btn(1, 0, 0);
    tick();
    set_btn(0, 0, 0);
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      tick();
      if (bus.fieldSel_out == 2'd2) found = 1;
    end
    chk("wait SET_MIN", 32'(found), 32'd1);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("blink %0d", i), 32'(bus.blink_out), 32'(((i / BLK) % 2) == 0));
      tick();
    end
    set_btn(0, 1, 0);
    repeat (28) tick();
    set_btn(0, 0, 0);
    repeat (3) tick();
    chk("repeat minute", 32'(bus.bcdMinute_out), 32'h16);
    repeat (12) tick();
    chk("after release", 32'(bus.bcdMinute_out), 32'h16);
    chk("repeat hour", 32'(bus.bcdHour_out), 32'h10);

    pulse(1, 0, 0, 1);
    chk("exit fs 3", 32'(bus.fieldSel_out), 32'd3);
    pulse(1, 0, 0, 1);
    chk("exit fs 0", 32'(bus.fieldSel_out), 32'd0);
    chk("exit adj", 32'(bus.adjustCmd_out), 32'd0);
    repeat (12) begin
      tick();
      chk("idle blink", 32'(bus.blink_out), 32'd1);
    end

    // Reset in the middle of an edit.
    pulse(1, 0, 0, 1);
    chk("edit adj", 32'(bus.adjustCmd_out), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midedit reset", 32'(act_vec()), 32'h0100_0000);

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) bus.modeBtn_in = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) bus.incBtn_in  = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 15) == 0) bus.decBtn_in  = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 3) == 0) set_time(rnd_bcd(23), rnd_bcd(59), rnd_bcd(59));
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
